lfsr16_sequence_checker: RTL and testbench



---
 rtl/lfsr16_sequence_checker.sv | 140 ++++++++++++++
 tb/tb_lfsr16_sequence_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr16_sequence_checker.sv
// Checks that a sampled 16-bit word stream follows the Galois LFSR successor rule.
// It hunts for a seed, verifies a run of successors, then locks and flywheels through isolated errors.
module lfsr16_sequence_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VALID,
  input  logic [15:0]      DATA,
  output logic             LOCKED,
  output logic             MATCH,
  output logic             ERROR,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] MATCH_COUNT,
  output logic [15:0]      EXPECTED
);

  localparam int RUN_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15]} ^ (x[15] ? 16'h6B8E : 16'h0000);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             r_state, w_state;
  logic [15:0]        r_ref, w_ref;
  logic [15:0]        r_expected, w_expected;
  logic [RUN_W-1:0]   r_run, w_run;
  logic [MISS_W-1:0]  r_miss, w_miss;
  logic               r_match, w_match;
  logic               r_error, w_error;
  logic [CNT_W-1:0]   r_err_cnt, w_err_cnt;
  logic [CNT_W-1:0]   r_match_cnt, w_match_cnt;
  logic [15:0]        w_pred;

  assign w_pred = lfsr_next(r_ref);

  always_comb begin
    w_state     = r_state;
    w_ref       = r_ref;
    w_run       = r_run;
    w_miss      = r_miss;
    w_match     = 1'b0;
    w_error     = 1'b0;
    w_err_cnt   = r_err_cnt;
    w_match_cnt = r_match_cnt;
    if (VALID) begin
      case (r_state)
        ST_HUNT: begin
          if (DATA != 16'h0000) begin
            w_ref   = DATA;
            w_run   = '0;
            w_state = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (DATA == 16'h0000) begin
            w_state = ST_HUNT;
          end else if (DATA == w_pred) begin
            w_ref = DATA;
            if (r_run == RUN_LAST) begin
              w_run   = '0;
              w_miss  = '0;
              w_state = ST_LOCKED;
            end else begin
              w_run = r_run + RUN_W'(1);
            end
          end else begin
            w_ref = DATA;
            w_run = '0;
          end
        end
        ST_LOCKED: begin
          if (DATA == w_pred) begin
            w_ref       = DATA;
            w_miss      = '0;
            w_match     = 1'b1;
            w_match_cnt = sat_inc(r_match_cnt);
          end else begin
            // Flywheel: advance the prediction from the expected value, not the bad sample.
            w_ref     = w_pred;
            w_error   = 1'b1;
            w_err_cnt = sat_inc(r_err_cnt);
            if (r_miss == MISS_LAST) begin
              w_miss  = '0;
              w_run   = '0;
              w_state = ST_HUNT;
            end else begin
              w_miss = r_miss + MISS_W'(1);
            end
          end
        end
        default: w_state = ST_HUNT;
      endcase
    end
    w_expected = lfsr_next(w_ref);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_HUNT;
      r_ref       <= '0;
      r_expected  <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_match     <= 1'b0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_ref       <= w_ref;
      r_expected  <= w_expected;
      r_run       <= w_run;
      r_miss      <= w_miss;
      r_match     <= w_match;
      r_error     <= w_error;
      r_err_cnt   <= w_err_cnt;
      r_match_cnt <= w_match_cnt;
    end
  end

  assign LOCKED      = (r_state == ST_LOCKED);
  assign MATCH       = r_match;
  assign ERROR       = r_error;
  assign ERR_COUNT   = r_err_cnt;
  assign MATCH_COUNT = r_match_cnt;
  assign EXPECTED    = r_expected;

endmodule

// File: tb/tb_lfsr16_sequence_checker.sv
// Bench for lfsr16_sequence_checker: three parameterisations driven by the same stream,
// each compared every cycle against a rule-level reference model.
module tb_lfsr16_sequence_checker;

  logic        CLK;
  logic        RESET;
  logic        VALID;
  logic [15:0] DATA;

  logic        lk [3];
  logic        mt [3];
  logic        er [3];
  logic [15:0] ex [3];
  logic [15:0] ec [3];
  logic [15:0] mc [3];
  logic [1:0]  ec_b, mc_b;

  assign ec[1] = {14'd0, ec_b};
  assign mc[1] = {14'd0, mc_b};

  lfsr16_sequence_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(3), .CNT_W(16)) dut_a (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .DATA(DATA),
    .LOCKED(lk[0]), .MATCH(mt[0]), .ERROR(er[0]),
    .ERR_COUNT(ec[0]), .MATCH_COUNT(mc[0]), .EXPECTED(ex[0]));

  lfsr16_sequence_checker #(.LOCK_COUNT(2), .UNLOCK_COUNT(8), .CNT_W(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .DATA(DATA),
    .LOCKED(lk[1]), .MATCH(mt[1]), .ERROR(er[1]),
    .ERR_COUNT(ec_b), .MATCH_COUNT(mc_b), .EXPECTED(ex[1]));

  lfsr16_sequence_checker #(.LOCK_COUNT(1), .UNLOCK_COUNT(1), .CNT_W(16)) dut_c (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .DATA(DATA),
    .LOCKED(lk[2]), .MATCH(mt[2]), .ERROR(er[2]),
    .ERR_COUNT(ec[2]), .MATCH_COUNT(mc[2]), .EXPECTED(ex[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: mode 0 = hunt, 1 = verify, 2 = locked.
  typedef struct {
    int mode;
    int refv;
    int run;
    int miss;
    int errc;
    int matchc;
    int match;
    int err;
  } mdl_t;

  mdl_t  m [3];
  int    lock_n   [3] = '{4, 2, 1};
  int    unlock_n [3] = '{3, 8, 1};
  int    cmax     [3] = '{65535, 3, 65535};
  string nm       [3] = '{"A", "B", "C"};

  int n_checks = 0;
  int n_errors = 0;

  // Successor as multiplication by x modulo the feedback polynomial.
  function automatic int nxt(input int x);
    int y;
    y = x * 2;
    if (y >= 32'h10000) y = y ^ 32'h16B8F;
    return y;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input bit rst, input bit vld, input int d,
                                input int lk_n, input int ul_n, input int cm);
    mdl_t n;
    n = cur;
    n.match = 0;
    n.err   = 0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (!vld) return n;
    case (cur.mode)
      0: if (d != 0) begin n.refv = d; n.run = 0; n.mode = 1; end
      1: begin
        if (d == 0) n.mode = 0;
        else if (d == nxt(cur.refv)) begin
          n.refv = d;
          n.run  = cur.run + 1;
          if (n.run == lk_n) begin n.mode = 2; n.miss = 0; end
        end else begin
          n.refv = d;
          n.run  = 0;
        end
      end
      default: begin
        if (d == nxt(cur.refv)) begin
          n.refv   = d;
          n.miss   = 0;
          n.match  = 1;
          n.matchc = (cur.matchc < cm) ? cur.matchc + 1 : cm;
        end else begin
          n.refv = nxt(cur.refv);
          n.miss = cur.miss + 1;
          n.err  = 1;
          n.errc = (cur.errc < cm) ? cur.errc + 1 : cm;
          if (n.miss == ul_n) begin n.mode = 0; n.run = 0; end
        end
      end
    endcase
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check_eq({nm[i], ".locked"},   {31'd0, lk[i]}, (m[i].mode == 2) ? 32'd1 : 32'd0);
      check_eq({nm[i], ".match"},    {31'd0, mt[i]}, m[i].match);
      check_eq({nm[i], ".error"},    {31'd0, er[i]}, m[i].err);
      check_eq({nm[i], ".err_cnt"},  {16'd0, ec[i]}, m[i].errc);
      check_eq({nm[i], ".match_cnt"},{16'd0, mc[i]}, m[i].matchc);
      check_eq({nm[i], ".expected"}, {16'd0, ex[i]}, nxt(m[i].refv));
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [15:0] d);
    RESET = r;
    VALID = v;
    DATA  = d;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) m[i] = step(m[i], r, v, int'(d), lock_n[i], unlock_n[i], cmax[i]);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    int   r;
    logic [15:0] d;
    RESET = 1'b1;
    VALID = 1'b0;
    DATA  = 16'h0000;
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};

    // Reset state
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0000);
    check_eq("reset.locked",   {31'd0, lk[0]}, 32'd0);
    check_eq("reset.expected", {16'd0, ex[0]}, 32'd0);

    // Lock acquisition on a walking one
    cycle(1'b0, 1'b1, 16'h0001);
    cycle(1'b0, 1'b1, 16'h0002);
    cycle(1'b0, 1'b1, 16'h0004);
    cycle(1'b0, 1'b1, 16'h0008);
    check_eq("acq.not_yet", {31'd0, lk[0]}, 32'd0);
    cycle(1'b0, 1'b1, 16'h0010);
    check_eq("acq.locked",   {31'd0, lk[0]}, 32'd1);
    check_eq("acq.expected", {16'd0, ex[0]}, 32'h0020);
    check_eq("acq.err_cnt",  {16'd0, ec[0]}, 32'd0);

    // Walk up to 0x4000, then through the feedback wrap
    d = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, d);
      d = d << 1;
    end
    check_eq("wrap.pre_cnt", {16'd0, mc[0]}, 32'd10);
    cycle(1'b0, 1'b1, 16'h8000);
    cycle(1'b0, 1'b1, 16'h6B8F);
    check_eq("wrap.match",     {31'd0, mt[0]}, 32'd1);
    check_eq("wrap.match_cnt", {16'd0, mc[0]}, 32'd12);
    check_eq("wrap.expected",  {16'd0, ex[0]}, 32'hD71E);

    // Flywheel through one bad sample
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0001);
    cycle(1'b0, 1'b1, 16'h0002);
    cycle(1'b0, 1'b1, 16'h0004);
    cycle(1'b0, 1'b1, 16'h0008);
    cycle(1'b0, 1'b1, 16'h0010);
    cycle(1'b0, 1'b1, 16'h1234);
    check_eq("fly.error",   {31'd0, er[0]}, 32'd1);
    check_eq("fly.err_cnt", {16'd0, ec[0]}, 32'd1);
    cycle(1'b0, 1'b1, 16'h0040);
    check_eq("fly.match",  {31'd0, mt[0]}, 32'd1);
    check_eq("fly.locked", {31'd0, lk[0]}, 32'd1);

    // Loss of lock, saturation on the narrow instance
    cycle(1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b1, 16'hFFFF);
    check_eq("loss.still_locked", {31'd0, lk[0]}, 32'd1);
    cycle(1'b0, 1'b1, 16'hFFFF);
    check_eq("loss.unlocked", {31'd0, lk[0]}, 32'd0);
    check_eq("loss.err_cnt",  {16'd0, ec[0]}, 32'd4);
    cycle(1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b1, 16'hFFFF);
    check_eq("sat.b_err_cnt", {16'd0, ec[1]}, 32'd3);
    check_eq("sat.b_locked",  {31'd0, lk[1]}, 32'd1);

    // Zero handling and gaps
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      idle(10);
      cycle(1'b0, 1'b1, 16'h0002 << k);
    end
    check_eq("gap.locked", {31'd0, lk[0]}, 32'd1);
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0100);
    cycle(1'b0, 1'b1, 16'h0200);
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0400);

    // Reset priority over a valid sample while locked
    cycle(1'b0, 1'b1, 16'h0800);
    cycle(1'b0, 1'b1, 16'h1000);
    cycle(1'b0, 1'b1, 16'h2000);
    cycle(1'b0, 1'b1, 16'h4000);
    cycle(1'b1, 1'b1, 16'h8000);
    check_eq("rstpri.locked",    {31'd0, lk[0]}, 32'd0);
    check_eq("rstpri.expected",  {16'd0, ex[0]}, 32'd0);
    check_eq("rstpri.match_cnt", {16'd0, mc[0]}, 32'd0);

    // Randomised stream biased towards valid successors
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      d = 16'(nxt(m[0].refv));
      else if (r < 55) d = 16'(nxt(m[1].refv));
      else if (r < 70) d = 16'($urandom);
      else if (r < 74) d = 16'h0000;
      else             d = 16'(nxt(m[2].refv));
      if (m[0].refv == 0 && r < 45) d = 16'($urandom_range(1, 65535));
      if (r >= 90)      cycle(1'b0, 1'b0, 16'($urandom));
      else if (k % 700 == 699) cycle(1'b1, 1'($urandom), d);
      else              cycle(1'b0, 1'b1, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
